// File: rtl/dsp_multi_ctr_if.sv
// ---------------------------------------------------------------------------
// dsp_multi_ctr_if
// Bundles the per-channel control, configuration and result signals of the
// multi-channel DSP counter.
//   enable[NC]        per-channel enable (gates load and count)
//   load[NC]          per-channel synchronous load of start_val
//   down[NC]          per-channel direction, 0 = up, 1 = down
//   start_val[NC]     load / reload value
//   end_val[NC]       wrap bound (upper when counting up, lower when down)
//   step[NC]          unsigned step per count
//   ctr_val[NC]       current counter value
//   wrap[NC]          one-cycle pulse when the reloaded value appears
// Modports: master drives controls and reads results, slave is the counter.
// ---------------------------------------------------------------------------
interface dsp_multi_ctr_if #(
    parameter int COUNTER_WIDTH = 32,
    parameter int NUM_CHANNELS  = 4,
    parameter int STEP_WIDTH    = 8
);
    logic [NUM_CHANNELS-1:0]  enable;
    logic [NUM_CHANNELS-1:0]  load;
    logic [NUM_CHANNELS-1:0]  down;
    logic [COUNTER_WIDTH-1:0] start_val [NUM_CHANNELS];
    logic [COUNTER_WIDTH-1:0] end_val   [NUM_CHANNELS];
    logic [STEP_WIDTH-1:0]    step      [NUM_CHANNELS];
    logic [COUNTER_WIDTH-1:0] ctr_val   [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  wrap;

    modport master (
        output enable, load, down, start_val, end_val, step,
        input  ctr_val, wrap
    );

    modport slave (
        input  enable, load, down, start_val, end_val, step,
        output ctr_val, wrap
    );
endinterface

// File: rtl/dsp_multi_ctr.sv
// ---------------------------------------------------------------------------
// dsp_multi_ctr
// NUM_CHANNELS independent loadable up/down counters with per-channel step,
// wrap bound and a one-cycle wrap pulse that coincides with the reload value.
// Bound checks are done one bit wider than the counter so the counter never
// wraps modulo 2^COUNTER_WIDTH.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (clears counters and outputs)
//   bus   dsp_multi_ctr_if.slave: controls in, ctr_val/wrap out
// Configuration macro:
//   DSP_CTR_OUT_REG_EN  adds one output register stage on ctr_val and wrap
//                       (2-cycle latency); internal counting is unchanged.
// ---------------------------------------------------------------------------
module dsp_multi_ctr #(
    parameter int COUNTER_WIDTH = 32,
    parameter int NUM_CHANNELS  = 4,
    parameter int STEP_WIDTH    = 8
) (
    input  logic             clk,
    input  logic             rst,
    dsp_multi_ctr_if.slave   bus
);

    localparam int CW = COUNTER_WIDTH;
    localparam int NC = NUM_CHANNELS;
    localparam int SW = STEP_WIDTH;

    logic [CW-1:0] ctr_q  [NC];
    logic [CW-1:0] ctr_d  [NC];
    logic [NC-1:0] wrap_q;
    logic [NC-1:0] wrap_d;
    // One extra bit: carry for up counts, sign for down counts.
    logic [CW:0]   nxt_s  [NC];
    logic [CW:0]   step_s [NC];

    // Next-state computation for every channel, in enable/load/count priority.
    always_comb begin
        for (int i = 0; i < NC; i++) begin
            ctr_d[i]  = ctr_q[i];
            wrap_d[i] = 1'b0;
            step_s[i] = {{(CW + 1 - SW){1'b0}}, bus.step[i]};
            nxt_s[i]  = {(CW + 1){1'b0}};
            if (!bus.enable[i]) begin
                ctr_d[i]  = ctr_q[i];
                wrap_d[i] = 1'b0;
            end else if (bus.load[i]) begin
                ctr_d[i]  = bus.start_val[i];
                wrap_d[i] = 1'b0;
            end else if (!bus.down[i]) begin
                nxt_s[i] = {1'b0, ctr_q[i]} + step_s[i];
                if (nxt_s[i] > {1'b0, bus.end_val[i]}) begin
                    ctr_d[i]  = bus.start_val[i];
                    wrap_d[i] = 1'b1;
                end else begin
                    ctr_d[i]  = nxt_s[i][CW-1:0];
                    wrap_d[i] = 1'b0;
                end
            end else begin
                nxt_s[i] = {1'b0, ctr_q[i]} - step_s[i];
                // A set top bit means the difference went negative.
                if (nxt_s[i][CW] || (nxt_s[i][CW-1:0] < bus.end_val[i])) begin
                    ctr_d[i]  = bus.start_val[i];
                    wrap_d[i] = 1'b1;
                end else begin
                    ctr_d[i]  = nxt_s[i][CW-1:0];
                    wrap_d[i] = 1'b0;
                end
            end
        end
    end

    // Counter and wrap-pulse state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NC; i++) begin
                ctr_q[i] <= {CW{1'b0}};
            end
            wrap_q <= {NC{1'b0}};
        end else begin
            for (int i = 0; i < NC; i++) begin
                ctr_q[i] <= ctr_d[i];
            end
            wrap_q <= wrap_d;
        end
    end

`ifdef DSP_CTR_OUT_REG_EN
    logic [CW-1:0] out_ctr_q  [NC];
    logic [NC-1:0] out_wrap_q;

    // Output pipeline stage modelling the DSP product register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NC; i++) begin
                out_ctr_q[i] <= {CW{1'b0}};
            end
            out_wrap_q <= {NC{1'b0}};
        end else begin
            for (int i = 0; i < NC; i++) begin
                out_ctr_q[i] <= ctr_q[i];
            end
            out_wrap_q <= wrap_q;
        end
    end

    assign bus.ctr_val = out_ctr_q;
    assign bus.wrap    = out_wrap_q;
`else
    assign bus.ctr_val = ctr_q;
    assign bus.wrap    = wrap_q;
`endif

endmodule

// File: tb/tb_dsp_multi_ctr.sv
// ---------------------------------------------------------------------------
// tb_dsp_multi_ctr
// Directed, table-driven bench for dsp_multi_ctr with hand-computed results,
// plus hand-written reset sequences. Works with or without
// DSP_CTR_OUT_REG_EN (expected values are aligned by the output latency).
// ---------------------------------------------------------------------------
module tb_dsp_multi_ctr;

    localparam int CW = 32;
    localparam int NC = 4;
    localparam int SW = 8;
`ifdef DSP_CTR_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int          ch;
        logic        en;
        logic        ld;
        logic        dn;
        logic [31:0] sv;
        logic [31:0] ev;
        logic [7:0]  st;
        logic [31:0] exp_val;
        logic        exp_wrap;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    vec_t vecs [$];

    dsp_multi_ctr_if #(.COUNTER_WIDTH(CW), .NUM_CHANNELS(NC), .STEP_WIDTH(SW)) bus_if ();

    dsp_multi_ctr #(.COUNTER_WIDTH(CW), .NUM_CHANNELS(NC), .STEP_WIDTH(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic add(input int ch, input logic en, input logic ld, input logic dn,
                       input logic [31:0] sv, input logic [31:0] ev, input logic [7:0] st,
                       input logic [31:0] exp_val, input logic exp_wrap);
        vec_t v;
        v.ch = ch; v.en = en; v.ld = ld; v.dn = dn;
        v.sv = sv; v.ev = ev; v.st = st;
        v.exp_val = exp_val; v.exp_wrap = exp_wrap;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus_if.enable = 4'b0000;
        bus_if.load   = 4'b0000;
    endtask

    task automatic drive_vec(input vec_t v);
        drive_idle();
        bus_if.enable[v.ch]    = v.en;
        bus_if.load[v.ch]      = v.ld;
        bus_if.down[v.ch]      = v.dn;
        bus_if.start_val[v.ch] = v.sv;
        bus_if.end_val[v.ch]   = v.ev;
        bus_if.step[v.ch]      = v.st;
    endtask

    task automatic check_all_zero(input string tag);
        for (int c = 0; c < NC; c++) begin
            check($sformatf("%s ctr[%0d]", tag, c), bus_if.ctr_val[c], 32'd0);
            check($sformatf("%s wrap[%0d]", tag, c), {31'd0, bus_if.wrap[c]}, 32'd0);
        end
    endtask

    initial begin
        int idx;
        clk   = 1'b0;
        rst   = 1'b1;
        n_vec = 0;
        n_err = 0;
        bus_if.enable = 4'b0000;
        bus_if.load   = 4'b0000;
        bus_if.down   = 4'b0000;
        for (int c = 0; c < NC; c++) begin
            bus_if.start_val[c] = 32'd0;
            bus_if.end_val[c]   = 32'd0;
            bus_if.step[c]      = 8'd0;
        end

        // ch, en, ld, dn, start, end, step, expected value, expected wrap
        // Load while disabled: ignored, ch0 stays 0.
        add(0, 1'b0, 1'b1, 1'b0, 32'd5, 32'd3, 8'd1, 32'd0, 1'b0);
        add(0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd3, 8'd1, 32'd0, 1'b0);
        add(0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd3, 8'd1, 32'd0, 1'b0);
        add(0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd3, 8'd1, 32'd0, 1'b0);
        // Up wrap from reset value: 1,2,3,0(wrap),1.
        add(0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd3, 8'd1, 32'd1, 1'b0);
        add(0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd3, 8'd1, 32'd2, 1'b0);
        add(0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd3, 8'd1, 32'd3, 1'b0);
        add(0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd3, 8'd1, 32'd0, 1'b1);
        add(0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd3, 8'd1, 32'd1, 1'b0);
        // Load then step-2: 11,13,15,11(wrap),13.
        add(1, 1'b1, 1'b1, 1'b0, 32'd11, 32'd15, 8'd2, 32'd11, 1'b0);
        add(1, 1'b1, 1'b0, 1'b0, 32'd11, 32'd15, 8'd2, 32'd13, 1'b0);
        add(1, 1'b1, 1'b0, 1'b0, 32'd11, 32'd15, 8'd2, 32'd15, 1'b0);
        add(1, 1'b1, 1'b0, 1'b0, 32'd11, 32'd15, 8'd2, 32'd11, 1'b1);
        add(1, 1'b1, 1'b0, 1'b0, 32'd11, 32'd15, 8'd2, 32'd13, 1'b0);
        // Down count: 10,7,4,10(wrap).
        add(2, 1'b1, 1'b1, 1'b1, 32'd10, 32'd4, 8'd3, 32'd10, 1'b0);
        add(2, 1'b1, 1'b0, 1'b1, 32'd10, 32'd4, 8'd3, 32'd7, 1'b0);
        add(2, 1'b1, 1'b0, 1'b1, 32'd10, 32'd4, 8'd3, 32'd4, 1'b0);
        add(2, 1'b1, 1'b0, 1'b1, 32'd10, 32'd4, 8'd3, 32'd10, 1'b1);
        // Top of range: the sum carries past 2^32 and must wrap, never show 2.
        add(3, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 8'd4, 32'hFFFF_FFFA, 1'b0);
        add(3, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 8'd4, 32'hFFFF_FFFE, 1'b0);
        add(3, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 8'd4, 32'hFFFF_FFFA, 1'b1);
        // Step 0 holds; with the bound already violated it reloads once.
        add(1, 1'b1, 1'b0, 1'b0, 32'd11, 32'd15, 8'd0, 32'd13, 1'b0);
        add(1, 1'b1, 1'b0, 1'b0, 32'd11, 32'd15, 8'd0, 32'd13, 1'b0);
        add(1, 1'b1, 1'b0, 1'b0, 32'd11, 32'd12, 8'd0, 32'd11, 1'b1);
        add(1, 1'b1, 1'b0, 1'b0, 32'd11, 32'd12, 8'd0, 32'd11, 1'b0);
        // Start beyond bound: reload and wrap every enabled cycle.
        add(2, 1'b1, 1'b1, 1'b0, 32'd20, 32'd10, 8'd1, 32'd20, 1'b0);
        add(2, 1'b1, 1'b0, 1'b0, 32'd20, 32'd10, 8'd1, 32'd20, 1'b1);
        add(2, 1'b1, 1'b0, 1'b0, 32'd20, 32'd10, 8'd1, 32'd20, 1'b1);
        // Down below zero counts as less than the bound; exactly equal does not.
        add(3, 1'b1, 1'b1, 1'b1, 32'd2, 32'd0, 8'd5, 32'd2, 1'b0);
        add(3, 1'b1, 1'b0, 1'b1, 32'd2, 32'd0, 8'd5, 32'd2, 1'b1);
        add(3, 1'b1, 1'b1, 1'b1, 32'd5, 32'd0, 8'd5, 32'd5, 1'b0);
        add(3, 1'b1, 1'b0, 1'b1, 32'd5, 32'd0, 8'd5, 32'd0, 1'b0);
        add(3, 1'b1, 1'b0, 1'b1, 32'd5, 32'd0, 8'd5, 32'd5, 1'b1);
        // ch0 held its value while other channels ran.
        add(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd3, 8'd1, 32'd1, 1'b0);
        // Load has priority over an out-of-bound count.
        add(0, 1'b1, 1'b1, 1'b0, 32'd7, 32'd3, 8'd1, 32'd7, 1'b0);
        add(0, 1'b1, 1'b0, 1'b0, 32'd7, 32'd3, 8'd1, 32'd7, 1'b1);

        // Reset state.
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Vector k is applied before edge k; its result is visible LAT-1 edges later.
        for (int k = 0; k < vecs.size() + LAT - 1; k++) begin
            if (k < vecs.size()) drive_vec(vecs[k]);
            else drive_idle();
            @(posedge clk);
            #1;
            idx = k - (LAT - 1);
            if (idx >= 0) begin
                check($sformatf("vec%0d ctr[%0d]", idx, vecs[idx].ch),
                      bus_if.ctr_val[vecs[idx].ch], vecs[idx].exp_val);
                check($sformatf("vec%0d wrap[%0d]", idx, vecs[idx].ch),
                      {31'd0, bus_if.wrap[vecs[idx].ch]}, {31'd0, vecs[idx].exp_wrap});
            end
        end

        // Async reset mid-count: all channels counting up by 1 from 0.
        for (int c = 0; c < NC; c++) begin
            bus_if.down[c]      = 1'b0;
            bus_if.start_val[c] = 32'd0;
            bus_if.end_val[c]   = 32'd100;
            bus_if.step[c]      = 8'd1;
        end
        bus_if.load   = 4'b1111;
        bus_if.enable = 4'b1111;
        @(posedge clk);
        #1;
        bus_if.load = 4'b0000;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        #1;
        rst = 1'b0;
        // Counting resumes from 0: value 1 appears LAT edges after release.
        repeat (LAT) @(posedge clk);
        #1;
        for (int c = 0; c < NC; c++) begin
            check($sformatf("resume ctr[%0d]", c), bus_if.ctr_val[c], 32'd1);
            check($sformatf("resume wrap[%0d]", c), {31'd0, bus_if.wrap[c]}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dsp_multi_ctr.md
# dsp_multi_ctr

Parametrised, multi-channel successor to the single loadable DSP counter. It provides `NUM_CHANNELS` independent counters. Each channel has its own enable, synchronous load, step size, direction and wrap bound, plus a one-cycle wrap pulse. The block sits in the TPU datapath sequencing logic and drives weight/activation address generation and loop counting for the systolic array. Counters map onto DSP accumulators, with an optional DSP-style output register.

## Interface
- `COUNTER_WIDTH`, 32, width of each counter, start and end value
- `NUM_CHANNELS`, 4, number of independent counter channels (≥1)
- `STEP_WIDTH`, 8, width of each channel's step value (≤ `COUNTER_WIDTH`)

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `enable`  in  `NUM_CHANNELS`  per-channel enable; gates load and count
- `load`  in  `NUM_CHANNELS`  per-channel synchronous load of `start_val`
- `down`  in  `NUM_CHANNELS`  per-channel direction: 0 = up, 1 = down
- `start_val`  in  `NUM_CHANNELS`×`COUNTER_WIDTH`  load/reload value, unpacked array `[NUM_CHANNELS]`
- `end_val`  in  `NUM_CHANNELS`×`COUNTER_WIDTH`  wrap bound: upper bound (up) or lower bound (down)
- `step`  in  `NUM_CHANNELS`×`STEP_WIDTH`  unsigned increment/decrement per count
- `ctr_val`  out  `NUM_CHANNELS`×`COUNTER_WIDTH`  current counter value per channel
- `wrap`  out  `NUM_CHANNELS`  one-cycle pulse on the cycle the reloaded value appears on `ctr_val`

## Operation
- Channels are fully independent; no shared state, and no cross-channel priority.
- Per channel i, at each rising edge, in priority order:
  - `enable[i]`=0: hold `ctr_val[i]` and ignore `load[i]`; `wrap[i]` is driven to 0.
  - `enable[i]`=1, `load[i]`=1: `ctr_val[i]` takes `start_val[i]`; `wrap[i]` is driven to 0.
  - `enable[i]`=1, `down[i]`=0: form `nxt = ctr + step` in `COUNTER_WIDTH+1` bits, zero-extended.
    - If `nxt > end_val`, reload `start_val` and set `wrap[i]`=1.
    - Otherwise take `nxt`; `wrap[i]`=0.
  - `enable[i]`=1, `down[i]`=1: form `nxt = ctr − step` in `COUNTER_WIDTH+1` bits, signed.
    - If `nxt < end_val` (negative counts as less), reload `start_val` and set `wrap[i]`=1.
    - Otherwise take `nxt`.
- Native modulo-2^W wrap never occurs; the bound check always uses the extra bit.
- `step`=0: the value holds while enabled and no wrap occurs, unless the bound is already violated.
- Start beyond the bound (e.g. up with `start_val > end_val`): the channel reloads and pulses `wrap` every enabled cycle.
- Reset: every `ctr_val` = 0 and every `wrap` = 0, immediately and independently of `clk`. Any count in progress is discarded.

## Timing
- Inputs are sampled at the rising edge. The result is visible on `ctr_val`/`wrap` after that edge, i.e. 1-cycle latency (2 with the output register, see Configuration).
- `wrap` is high for exactly one cycle per wrap event. It coincides with `start_val` appearing on `ctr_val`.
- `start_val`, `end_val`, `step` and `down` may change on any cycle; they take effect at the next edge where they are used.
- Deasserting `rst` leaves the counters at 0; the first count or load happens on the first edge after release.

## Configuration
- `DSP_CTR_OUT_REG_EN` defined: adds one pipeline register stage on `ctr_val` and `wrap`, modelling a DSP PREG.
  - Both outputs lag the internal counter by 1 cycle, giving 2-cycle latency from input sample to output.
  - Internal counting is unchanged.
  - `rst` clears both the counter and the output stage asynchronously.
- Undefined: outputs are driven directly from the counter registers (1-cycle latency).

## Test plan
- Load while disabled: ch0 `enable`=0, `load`=1, `start_val`=5 for one cycle. Expect `ctr_val[0]`=0 and `wrap[0]`=0 for the next 4 cycles.
- Up wrap after reset: ch0 `enable`=1, `step`=1, `start_val`=0, `end_val`=3. Expect `ctr_val[0]` to sequence 1,2,3,0,1, with `wrap[0]` high only on the cycle showing 0.
- Load then step-2 count: ch1 `load`+`enable` with `start_val`=11, then `step`=2, `end_val`=15. Expect 11,13,15,11 (wrap pulse), 13.
- Down count: ch2 `down`=1, load `start_val`=10, `end_val`=4, `step`=3. Expect 10,7,4,10 (wrap pulse). With `COUNTER_WIDTH`=8: ch3 up, `start_val`=250, `end_val`=255, `step`=4 gives 250,254,250 (wrap pulse), never 2. Disabled ch0 holds throughout.
- Async reset mid-count: assert `rst` between clock edges while ch0–3 are counting. Expect all `ctr_val`=0 and all `wrap`=0 before the next edge. Counting resumes from 0 after release. Repeat with `DSP_CTR_OUT_REG_EN` defined and check 2-cycle latency in the up-wrap scenario.
